// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
//
// Purpose : sweep FSM state encoding and default geometry constants used by
//           regfile_multiport and regfile_read_port.
// Contents: rf_state_e      - RF_CLEAR (clear sweep running), RF_READY (normal operation)
//           RF_XLEN_DEFAULT - default data width
//           RF_NREG_DEFAULT - default register count
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int RF_XLEN_DEFAULT = 64;
    localparam int RF_NREG_DEFAULT = 32;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read lane of the multi-port register file
//
// Purpose : selects one register from the flattened storage, optionally forwards
//           same-cycle write data, and forces zero for x0 and while clearing.
// Ports   : regs_i     in  NREG*XLEN  flattened storage, register r at [r*XLEN +: XLEN]
//           rd_addr_i  in  AW         register to read
//           state_i    in  rf_state_e sweep FSM state
//           wr_en_i    in  NWR        write enables of all write ports
//           wr_addr_i  in  NWR*AW     write addresses, port p at [p*AW +: AW]
//           wr_data_i  in  NWR*XLEN   write data, port p at [p*XLEN +: XLEN]
//           rd_data_o  out XLEN       read result
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN_DEFAULT,
    parameter int NREG   = RF_NREG_DEFAULT,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic [NREG*XLEN-1:0] regs_i,
    input  logic [AW-1:0]        rd_addr_i,
    input  rf_state_e            state_i,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    output logic [XLEN-1:0]      rd_data_o
);

    always_comb begin
        rd_data_o = regs_i[int'(rd_addr_i) * XLEN +: XLEN];

        // Ascending scan so the highest-index matching write port is the one left standing,
        // mirroring the write-side priority so bypassed and stored values agree.
        if (BYPASS != 0 && state_i == RF_READY) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p] && wr_addr_i[p*AW +: AW] == rd_addr_i) begin
                    rd_data_o = wr_data_i[p*XLEN +: XLEN];
                end
            end
        end

        // Applied last so neither a bypass hit on x0 nor stale storage during the sweep leaks out.
        if (state_i != RF_READY || rd_addr_i == '0) begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised multi-port integer register file with clear sweep
//
// Purpose : NREG x XLEN storage with NRD combinational read ports, NWR write ports
//           (highest port wins on conflict), x0 hardwired to zero, optional write-to-read
//           bypass and a registered debug read port. Storage has no reset; after reset a
//           sweep writes zero to one register per cycle so the array can map to RAM.
// Ports   : clk       in  1         clock
//           reset     in  1         synchronous, active-high reset
//           rs_addr   in  NRD*AW    read addresses, port p at [p*AW +: AW]
//           rs_data   out NRD*XLEN  read data (combinational), port p at [p*XLEN +: XLEN]
//           wr_en     in  NWR       per-port write enable
//           wr_addr   in  NWR*AW    write addresses
//           wr_data   in  NWR*XLEN  write data
//           dbg_addr  in  AW        debug read address
//           dbg_data  out XLEN      registered debug read data, no bypass
//           ready     out 1         high once the clear sweep has finished
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN_DEFAULT,
    parameter int NREG   = RF_NREG_DEFAULT,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic                ready
);

    rf_state_e             state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  clear_we;
    logic [XLEN-1:0]       mem_q [NREG];
    logic [NREG*XLEN-1:0]  mem_flat;
    logic [XLEN-1:0]       dbg_q, dbg_d;

    // Sweep FSM: reset parks in CLEAR with cnt = 0; each following edge clears reg[cnt].
    // The edge that clears the last register hands over to READY, so cnt never wraps.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_we = 1'b0;
        if (reset) begin
            state_d = RF_CLEAR;
            cnt_d   = '0;
        end else if (state_q == RF_CLEAR) begin
            clear_we = 1'b1;
            if (cnt_q == AW'(NREG - 1)) begin
                state_d = RF_READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Storage: no reset term so it stays RAM-friendly. Later ports overwrite earlier ones
    // in the loop, giving the highest port index priority on address conflicts.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[cnt_q] <= '0;
        end else if (!reset && state_q == RF_READY) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] != '0) begin
                    mem_q[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_flat
        assign mem_flat[r*XLEN +: XLEN] = mem_q[r];
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_read_port #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .NWR    (NWR),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_read_port (
            .regs_i    (mem_flat),
            .rd_addr_i (rs_addr[p*AW +: AW]),
            .state_i   (state_q),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_data_o (rs_data[p*XLEN +: XLEN])
        );
    end

    // Debug read samples stored contents only; held at zero until the sweep is done.
    always_comb begin
        dbg_d = '0;
        if (state_q == RF_READY && dbg_addr != '0) begin
            dbg_d = mem_q[dbg_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign dbg_data = dbg_q;
    assign ready    = (state_q == RF_READY);

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;

    logic         clk = 1'b0;
    logic         reset;
    logic [9:0]   rs_addr;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic [4:0]   dbg_addr;

    logic [127:0] rs_data_b, rs_data_n;
    logic [63:0]  dbg_data_b, dbg_data_n;
    logic         ready_b, ready_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_multiport #(.BYPASS(1)) u_byp (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data_b),
        .ready    (ready_b)
    );

    regfile_multiport #(.BYPASS(0)) u_nob (
        .clk      (clk),
        .reset    (reset),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data_n),
        .ready    (ready_n)
    );

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [63:0] d);
        wr_en[p]            = en;
        wr_addr[p*5 +: 5]   = a;
        wr_data[p*64 +: 64] = d;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
        #1;
    endtask

    // Deassert reset and run the 32-edge sweep, checking ready on every edge for both DUTs.
    task automatic run_sweep(input string tag);
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            chk_val({tag, "_ready_b"}, 64'(ready_b), 64'(i == 32));
            chk_val({tag, "_ready_n"}, 64'(ready_n), 64'(i == 32));
            if (i < 32) begin
                chk_val({tag, "_clr_rs_b"}, rs_data_b[63:0], 64'h0);
                chk_val({tag, "_clr_dbg_b"}, dbg_data_b, 64'h0);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        rs_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        dbg_addr = '0;
        step();
        step();
        chk_val("rst_ready", 64'(ready_b), 64'h0);
        chk_val("rst_dbg", dbg_data_b, 64'h0);
        chk_val("rst_rs0", rs_data_b[63:0], 64'h0);
        chk_val("rst_rs1", rs_data_b[127:64], 64'h0);

        // Writes attempted during the sweep must be dropped and not bypassed.
        set_wr(0, 1'b1, 5'd3, 64'd9);
        set_rd(5'd3, 5'd3);
        run_sweep("sweep1");
        set_wr(0, 1'b0, 5'd0, 64'd0);

        for (int r = 0; r < 32; r += 2) begin
            set_rd(5'(r), 5'(r + 1));
            chk_val("idle_rs0", rs_data_b[63:0], 64'h0);
            chk_val("idle_rs1", rs_data_b[127:64], 64'h0);
        end
        set_rd(5'd3, 5'd3);
        chk_val("clr_drop_x3_n", rs_data_n[63:0], 64'h0);

        // Both ports to x5: port1 wins, both in bypass and in storage.
        set_wr(0, 1'b1, 5'd5, 64'hAAAA);
        set_wr(1, 1'b1, 5'd5, 64'h5555);
        set_rd(5'd5, 5'd0);
        chk_val("x5_bypass_prio", rs_data_b[63:0], 64'h5555);
        chk_val("x5_nobyp_old", rs_data_n[63:0], 64'h0);
        step();
        set_wr(0, 1'b0, 5'd0, 64'd0);
        set_wr(1, 1'b0, 5'd0, 64'd0);
        #1;
        chk_val("x5_stored_b", rs_data_b[63:0], 64'h5555);
        chk_val("x5_stored_n", rs_data_n[63:0], 64'h5555);

        // Same-cycle bypass on lane1 vs. one-cycle-late visibility without bypass.
        set_wr(0, 1'b1, 5'd7, 64'h1234);
        set_rd(5'd5, 5'd7);
        chk_val("x7_bypass_b", rs_data_b[127:64], 64'h1234);
        chk_val("x7_old_n", rs_data_n[127:64], 64'h0);
        chk_val("x5_lane0_b", rs_data_b[63:0], 64'h5555);
        step();
        set_wr(0, 1'b0, 5'd0, 64'd0);
        #1;
        chk_val("x7_next_n", rs_data_n[127:64], 64'h1234);
        chk_val("x7_next_b", rs_data_b[127:64], 64'h1234);

        // x0 writes: nothing stored, nothing forwarded.
        set_wr(0, 1'b1, 5'd0, 64'hFFFF);
        set_wr(1, 1'b1, 5'd0, 64'hFFFF);
        dbg_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        chk_val("x0_byp_rs0", rs_data_b[63:0], 64'h0);
        chk_val("x0_byp_rs1", rs_data_b[127:64], 64'h0);
        step();
        set_wr(0, 1'b0, 5'd0, 64'd0);
        set_wr(1, 1'b0, 5'd0, 64'd0);
        #1;
        chk_val("x0_rs_n", rs_data_n[63:0], 64'h0);
        step();
        chk_val("x0_dbg_b", dbg_data_b, 64'h0);
        chk_val("x0_dbg_n", dbg_data_n, 64'h0);

        // Debug latency: write x3 = 9 at edge E, dbg shows it after E+1.
        dbg_addr = 5'd3;
        set_wr(1, 1'b1, 5'd3, 64'd9);
        step();
        set_wr(1, 1'b0, 5'd0, 64'd0);
        chk_val("dbg_x3_at_E", dbg_data_b, 64'h0);
        step();
        chk_val("dbg_x3_E1_b", dbg_data_b, 64'd9);
        chk_val("dbg_x3_E1_n", dbg_data_n, 64'd9);
        dbg_addr = 5'd5;
        step();
        chk_val("dbg_x5", dbg_data_b, 64'h5555);

        // Reset from READY with live contents, then reset again at sweep cycle 10.
        reset = 1'b1;
        set_rd(5'd5, 5'd7);
        step();
        chk_val("rst2_ready", 64'(ready_b), 64'h0);
        chk_val("rst2_dbg", dbg_data_b, 64'h0);
        chk_val("rst2_rs0", rs_data_b[63:0], 64'h0);
        chk_val("rst2_rs1", rs_data_n[127:64], 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_val("mid_ready", 64'(ready_b), 64'h0);
        end
        reset = 1'b1;
        step();
        run_sweep("sweep2");
        chk_val("post_x5_b", rs_data_b[63:0], 64'h0);
        chk_val("post_x7_n", rs_data_n[127:64], 64'h0);
        step();
        chk_val("post_dbg_x5", dbg_data_b, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
